// File: rtl/calc_pkg.sv
// Shared calculator definitions: keypad button codes and the keypad scanner state encoding.
package calc_pkg;

  localparam logic [7:0] BTN_NONE  = 8'h00;
  localparam logic [7:0] BTN_CLEAR = 8'h04;
  localparam logic [7:0] BTN_1     = 8'h05;
  localparam logic [7:0] BTN_4     = 8'h06;
  localparam logic [7:0] BTN_7     = 8'h07;
  localparam logic [7:0] BTN_0     = 8'h14;
  localparam logic [7:0] BTN_2     = 8'h15;
  localparam logic [7:0] BTN_5     = 8'h16;
  localparam logic [7:0] BTN_8     = 8'h17;
  localparam logic [7:0] BTN_EQ    = 8'h24;
  localparam logic [7:0] BTN_3     = 8'h25;
  localparam logic [7:0] BTN_6     = 8'h26;
  localparam logic [7:0] BTN_9     = 8'h27;
  localparam logic [7:0] BTN_DIV   = 8'h34;
  localparam logic [7:0] BTN_MUL   = 8'h35;
  localparam logic [7:0] BTN_SUB   = 8'h36;
  localparam logic [7:0] BTN_ADD   = 8'h37;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CONFIRM,
    ST_HELD,
    ST_RELEASE
  } scan_state_t;

  // Column in the high nibble, row offset by 4 in the low nibble.
  function automatic logic [7:0] key_code(input logic [1:0] col, input logic [1:0] row);
    return {4'(col), 4'(row) + 4'd4};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; both stages clear on reset.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with frame-based press/release debouncing.
module keypad_scanner
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [7:0] button,
  output logic       key_valid,
  output logic       key_strobe
);

  localparam int unsigned STEP_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_FRAMES - 1);

  logic [3:0]        row_sync;
  logic [STEP_W-1:0] step_cnt;
  logic [1:0]        col_idx;
  logic              acc_valid;
  logic [7:0]        acc_code;

  logic              row_hit;
  logic [1:0]        row_sel;
  logic              sample;
  logic              frame_end;
  logic              acc_live;
  logic              frame_hit;
  logic [7:0]        frame_code;

  scan_state_t       state, state_d;
  logic [7:0]        pending, pending_d;
  logic [CNT_W-1:0]  stable_cnt, stable_d;
  logic [CNT_W-1:0]  rel_cnt, rel_d;
  logic [7:0]        button_d;
  logic              valid_d;
  logic              strobe_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v >= CNT_MAX) ? CNT_MAX : v + CNT_W'(1);
  endfunction

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_sync)
  );

  // Lowest low row wins within a column.
  always_comb begin
    row_hit = 1'b0;
    row_sel = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync[r]) begin
        row_hit = 1'b1;
        row_sel = 2'(r);
      end
    end
  end

  assign sample     = (step_cnt == STEP_LAST);
  assign frame_end  = sample && (col_idx == 2'd3);
  assign acc_live   = acc_valid && (col_idx != 2'd0);
  assign frame_hit  = acc_live || row_hit;
  assign frame_code = acc_live ? acc_code : key_code(col_idx, row_sel);

  // Column rotation and per-frame first-hit accumulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt  <= '0;
      col_idx   <= 2'd0;
      col_out   <= 4'b1110;
      acc_valid <= 1'b0;
      acc_code  <= 8'h00;
    end else if (sample) begin
      step_cnt  <= '0;
      col_idx   <= col_idx + 2'd1;
      col_out   <= ~(4'b0001 << (col_idx + 2'd1));
      acc_valid <= frame_hit;
      acc_code  <= frame_code;
    end else begin
      step_cnt  <= step_cnt + STEP_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      pending    <= 8'h00;
      stable_cnt <= '0;
      rel_cnt    <= '0;
      button     <= BTN_NONE;
      key_valid  <= 1'b0;
      key_strobe <= 1'b0;
    end else begin
      state      <= state_d;
      pending    <= pending_d;
      stable_cnt <= stable_d;
      rel_cnt    <= rel_d;
      button     <= button_d;
      key_valid  <= valid_d;
      key_strobe <= strobe_d;
    end
  end

  // Debounce FSM; decisions only on the frame-end cycle.
  always_comb begin
    state_d   = state;
    pending_d = pending;
    stable_d  = stable_cnt;
    rel_d     = rel_cnt;
    button_d  = button;
    valid_d   = key_valid;
    strobe_d  = 1'b0;
    if (frame_end) begin
      unique case (state)
        ST_IDLE: begin
          if (frame_hit) begin
            if (DEBOUNCE_FRAMES == 1) begin
              button_d = frame_code;
              valid_d  = 1'b1;
              strobe_d = 1'b1;
              state_d  = ST_HELD;
            end else begin
              pending_d = frame_code;
              stable_d  = CNT_W'(1);
              state_d   = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (!frame_hit) begin
            stable_d = '0;
            state_d  = ST_IDLE;
          end else if (frame_code == pending) begin
            if (stable_cnt >= CNT_LAST) begin
              button_d = pending;
              valid_d  = 1'b1;
              strobe_d = 1'b1;
              stable_d = '0;
              state_d  = ST_HELD;
            end else begin
              stable_d = sat_inc(stable_cnt);
            end
          end else begin
            pending_d = frame_code;
            stable_d  = CNT_W'(1);
          end
        end
        ST_HELD: begin
          if (!(frame_hit && frame_code == button)) begin
            if (DEBOUNCE_FRAMES == 1) begin
              button_d = BTN_NONE;
              valid_d  = 1'b0;
              state_d  = ST_IDLE;
            end else begin
              rel_d   = CNT_W'(1);
              state_d = ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (frame_hit && frame_code == button) begin
            rel_d   = '0;
            state_d = ST_HELD;
          end else if (rel_cnt >= CNT_LAST) begin
            button_d = BTN_NONE;
            valid_d  = 1'b0;
            rel_d    = '0;
            state_d  = ST_IDLE;
          end else begin
            rel_d = sat_inc(rel_cnt);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix (SCAN_DIV=4, DEBOUNCE_FRAMES=2).
module tb_keypad_scanner;

  localparam int unsigned SCAN_DIV = 4;
  localparam int unsigned DEB      = 2;
  localparam int unsigned FRAME    = 4 * SCAN_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [7:0] button;
  logic       key_valid;
  logic       key_strobe;

  logic [15:0] keys = '0;   // bit c*4+r = key at column c, row r pressed

  int   n_checks = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   zero_cycles = 0;
  bit   direct_switch = 1'b0;
  bit   long_strobe = 1'b0;
  bit   valid_drop = 1'b0;
  bit   idle_bad = 1'b0;
  logic [7:0] prev_button = 8'h00;
  logic       prev_strobe = 1'b0;
  logic [3:0] exp_col;

  keypad_scanner #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_FRAMES(DEB)) dut (
    .clk        (clk),
    .rst        (rst),
    .row_in     (row_in),
    .col_out    (col_out),
    .button     (button),
    .key_valid  (key_valid),
    .key_strobe (key_strobe)
  );

  always #5 clk = ~clk;

  // Pressed keys short the driven (low) column onto their row.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (!col_out[c] && keys[c*4+r]) row_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (key_strobe) strobe_cnt++;
    if (key_strobe && prev_strobe) long_strobe = 1'b1;
    if (prev_button == 8'h37 && button == 8'h24) direct_switch = 1'b1;
    if (button == 8'h00) zero_cycles++;
    if (!key_valid) valid_drop = 1'b1;
    prev_button = button;
    prev_strobe = key_strobe;
  endtask

  task automatic align();
    while (cyc % FRAME != 0) tick();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    // reset values
    rst = 1'b1;
    run(2);
    check("rst_col", 32'(col_out), 32'h0E);
    check("rst_button", 32'(button), 32'h00);
    check("rst_valid", 32'(key_valid), 32'h0);
    check("rst_strobe", 32'(key_strobe), 32'h0);
    rst = 1'b0;
    cyc = 0;

    // idle scan rotation, 4 cycles per column
    for (int i = 0; i < 16; i++) begin
      exp_col = ~(4'b0001 << (i / 4));
      check($sformatf("scan_col_%0d", i), 32'(col_out), 32'(exp_col));
      if (button != 8'h00 || key_valid) idle_bad = 1'b1;
      tick();
    end
    check("idle_outputs", 32'(idle_bad), 32'h0);

    // '3' = column 2, row 1
    strobe_cnt = 0;
    keys[2*4+1] = 1'b1;
    run(2 * FRAME + 4);
    check("press3_strobes", 32'(strobe_cnt), 32'd1);
    check("press3_button", 32'(button), 32'h25);
    check("press3_valid", 32'(key_valid), 32'h1);

    // one dropped frame while held is tolerated
    align();
    strobe_cnt = 0;
    valid_drop = 1'b0;
    keys = '0;
    run(FRAME);
    keys[2*4+1] = 1'b1;
    run(2 * FRAME);
    check("bounce_button", 32'(button), 32'h25);
    check("bounce_strobes", 32'(strobe_cnt), 32'd0);
    check("bounce_valid_held", 32'(valid_drop), 32'h0);
    align();
    keys = '0;
    run(2 * FRAME + 2);
    check("release_button", 32'(button), 32'h00);
    check("release_valid", 32'(key_valid), 32'h0);

    // c0r3 and c2r0 together: lowest column wins -> '7'
    align();
    strobe_cnt = 0;
    keys[0*4+3] = 1'b1;
    keys[2*4+0] = 1'b1;
    run(2 * FRAME + 2);
    check("multi_button", 32'(button), 32'h07);
    check("multi_strobes", 32'(strobe_cnt), 32'd1);
    keys = '0;
    run(3 * FRAME);
    check("multi_release", 32'(key_valid), 32'h0);

    // one-frame pulses never accepted
    align();
    strobe_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      keys[1*4+1] = (k % 2 == 0);
      run(FRAME);
    end
    check("pulse_strobes", 32'(strobe_cnt), 32'd0);
    check("pulse_valid", 32'(key_valid), 32'h0);

    // reset while in CONFIRM discards the partial debounce
    keys[1*4+1] = 1'b1;
    run(FRAME + 6);
    rst = 1'b1;
    tick();
    check("midrst_col", 32'(col_out), 32'h0E);
    check("midrst_button", 32'(button), 32'h00);
    check("midrst_valid", 32'(key_valid), 32'h0);
    check("midrst_strobe", 32'(key_strobe), 32'h0);
    rst = 1'b0;
    cyc = 0;
    strobe_cnt = 0;
    run(FRAME + 2);
    check("midrst_no_early", 32'(strobe_cnt), 32'd0);
    run(FRAME);
    check("midrst_accept", 32'(strobe_cnt), 32'd1);
    check("midrst_button2", 32'(button), 32'h15);
    keys = '0;
    run(3 * FRAME);

    // '+' then '=' must pass through a released state
    align();
    strobe_cnt = 0;
    keys[3*4+3] = 1'b1;
    run(2 * FRAME + 2);
    check("plus_button", 32'(button), 32'h37);
    align();
    zero_cycles = 0;
    direct_switch = 1'b0;
    keys = '0;
    keys[2*4+0] = 1'b1;
    run(4 * FRAME + 2);
    check("eq_button", 32'(button), 32'h24);
    check("switch_strobes", 32'(strobe_cnt), 32'd2);
    check("switch_gap", 32'(zero_cycles > 0), 32'h1);
    check("switch_direct", 32'(direct_switch), 32'h0);
    check("strobe_width", 32'(long_strobe), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
